// File: rtl/osd_overlay_multigun.sv
// Final compositor: core video + OSD layer (opaque/translucent) + up to NUM_GUNS lightgun
// crosshairs with per-frame coordinate capture and multi-frame trigger flash.
module osd_overlay_multigun #(
  parameter int         COLOR_W      = 8,
  parameter int         NUM_GUNS     = 2,
  parameter int         PIPE_DEPTH   = 2,
  parameter int         CROSS_SIZE   = 4,
  parameter int         MAX_X        = 319,
  parameter int         MAX_Y        = 239,
  parameter int         FLASH_FRAMES = 4,
  parameter int         BLEND_SHIFT  = 1,
  parameter logic [7:0] GRAY         = 8'hA0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pixel_ce,
  input  logic [COLOR_W-1:0]        R_in,
  input  logic [COLOR_W-1:0]        G_in,
  input  logic [COLOR_W-1:0]        B_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblank_in,
  input  logic                      vblank_in,
  input  logic [11:0]               x_pix,
  input  logic [11:0]               y_pix,
  input  logic                      osd_opaque,
  input  logic [3*COLOR_W-1:0]      osd_rgb,
  input  logic                      osd_tint,
  input  logic [NUM_GUNS-1:0]       gun_enable,
  input  logic [NUM_GUNS-1:0]       gun_trigger,
  input  logic [12*NUM_GUNS-1:0]    gun_x,
  input  logic [12*NUM_GUNS-1:0]    gun_y,
  output logic [COLOR_W-1:0]        R_out,
  output logic [COLOR_W-1:0]        G_out,
  output logic [COLOR_W-1:0]        B_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblank_out,
  output logic                      vblank_out
);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               hs;
    logic               vs;
    logic               hb;
    logic               vb;
  } px_t;

  localparam px_t PX_RESET = '{r: '0, g: '0, b: '0, hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1};

  // GRAY is an 8-bit level; take its top COLOR_W bits so it scales with channel width.
  localparam logic [COLOR_W+7:0]   GRAY_WIDE = {GRAY, {COLOR_W{1'b0}}};
  localparam logic [COLOR_W-1:0]   GRAY_C    = GRAY_WIDE[COLOR_W+7 -: COLOR_W];
  localparam logic [COLOR_W-1:0]   TINT_ADD  = GRAY_C >> 2;

  function automatic logic [COLOR_W-1:0] tint_ch(input logic [COLOR_W-1:0] bg);
    logic [COLOR_W:0] sum;
    sum = {1'b0, bg >> BLEND_SHIFT} + {1'b0, TINT_ADD};
    return sum[COLOR_W] ? {COLOR_W{1'b1}} : sum[COLOR_W-1:0];
  endfunction

  function automatic logic [3*COLOR_W-1:0] gun_colour(input int idx, input logic flashing);
    logic [COLOR_W-1:0] on;
    logic [COLOR_W-1:0] off;
    on  = '1;
    off = '0;
    if (flashing) return {on, off, off};
    case (idx % 4)
      0:       return {off, on,  off};
      1:       return {off, on,  on};
      2:       return {on,  on,  off};
      default: return {on,  off, on};
    endcase
  endfunction

  // ---------------------------------------------------------------- gun state
  logic [11:0]         lat_x [NUM_GUNS];
  logic [11:0]         lat_y [NUM_GUNS];
  logic [3:0]          flash [NUM_GUNS];
  logic [NUM_GUNS-1:0] trig_prev;
  logic [NUM_GUNS-1:0] trig_rise;
  logic                vb_prev;
  logic                vb_rise;

  assign vb_rise   = vblank_in & ~vb_prev;
  assign trig_rise = gun_trigger & ~trig_prev;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      vb_prev   <= 1'b0;
      trig_prev <= '0;
      for (int i = 0; i < NUM_GUNS; i++) begin
        lat_x[i] <= 12'hFFF;
        lat_y[i] <= 12'hFFF;
        flash[i] <= 4'd0;
      end
    end else if (pixel_ce) begin
      vb_prev   <= vblank_in;
      trig_prev <= gun_trigger;
      for (int i = 0; i < NUM_GUNS; i++) begin
        if (vb_rise) begin
          lat_x[i] <= gun_x[12*i +: 12];
          lat_y[i] <= gun_y[12*i +: 12];
        end
        // A trigger edge reloads even when it coincides with the frame tick.
        if (trig_rise[i])
          flash[i] <= 4'(FLASH_FRAMES);
        else if (vb_rise && flash[i] != 4'd0)
          flash[i] <= flash[i] - 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------- hit test
  logic [NUM_GUNS-1:0] hit_now;

  for (genvar g = 0; g < NUM_GUNS; g++) begin : g_hit
    logic [11:0] lo_x, hi_x, lo_y, hi_y;
    logic [12:0] sum_x, sum_y;
    logic        on_screen, h_arm, v_arm;

    assign lo_x  = (lat_x[g] >= 12'(CROSS_SIZE)) ? lat_x[g] - 12'(CROSS_SIZE) : 12'd0;
    assign lo_y  = (lat_y[g] >= 12'(CROSS_SIZE)) ? lat_y[g] - 12'(CROSS_SIZE) : 12'd0;
    assign sum_x = {1'b0, lat_x[g]} + 13'(CROSS_SIZE);
    assign sum_y = {1'b0, lat_y[g]} + 13'(CROSS_SIZE);
    assign hi_x  = (sum_x > 13'(MAX_X)) ? 12'(MAX_X) : sum_x[11:0];
    assign hi_y  = (sum_y > 13'(MAX_Y)) ? 12'(MAX_Y) : sum_y[11:0];

    assign on_screen  = (lat_x[g] <= 12'(MAX_X)) && (lat_y[g] <= 12'(MAX_Y));
    assign h_arm      = (x_pix >= lo_x) && (x_pix <= hi_x) && (y_pix == lat_y[g]);
    assign v_arm      = (y_pix >= lo_y) && (y_pix <= hi_y) && (x_pix == lat_x[g]);
    assign hit_now[g] = gun_enable[g] & on_screen & (h_arm | v_arm);
  end

  // ---------------------------------------------------------------- pipeline
  px_t                 pipe     [1:PIPE_DEPTH];
  logic [NUM_GUNS-1:0] hit_pipe [1:PIPE_DEPTH];

  // NOTE: the delay line is reset (not left as uninitialised storage) so a mid-frame
  // reset refills the output with blanked, crosshair-free pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= PIPE_DEPTH; i++) begin
        pipe[i]     <= PX_RESET;
        hit_pipe[i] <= '0;
      end
    end else if (pixel_ce) begin
      pipe[1]     <= '{r: R_in, g: G_in, b: B_in, hs: hsync_in, vs: vsync_in,
                       hb: hblank_in, vb: vblank_in};
      hit_pipe[1] <= hit_now;
      for (int i = 2; i <= PIPE_DEPTH; i++) begin
        pipe[i]     <= pipe[i-1];
        hit_pipe[i] <= hit_pipe[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- composite
  px_t                  cur;
  logic [3*COLOR_W-1:0] comp;

  assign cur = pipe[PIPE_DEPTH];

  // NOTE: comp gets its default before any conditional override, so no latch is inferred.
  always_comb begin
    comp = {cur.r, cur.g, cur.b};
    if (osd_tint)   comp = {tint_ch(cur.r), tint_ch(cur.g), tint_ch(cur.b)};
    if (osd_opaque) comp = osd_rgb;
    // Walk from the highest index down so the lowest-index hit is applied last and wins.
    for (int i = NUM_GUNS - 1; i >= 0; i--) begin
      if (hit_pipe[PIPE_DEPTH][i]) comp = gun_colour(i, flash[i] != 4'd0);
    end
    if (cur.hb || cur.vb) comp = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      R_out      <= '0;
      G_out      <= '0;
      B_out      <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblank_out <= 1'b1;
      vblank_out <= 1'b1;
    end else if (pixel_ce) begin
      {R_out, G_out, B_out} <= comp;
      hsync_out  <= cur.hs;
      vsync_out  <= cur.vs;
      hblank_out <= cur.hb;
      vblank_out <= cur.vb;
    end
  end

endmodule
